// File: rtl/ddram_mux_if.sv
// ddram_mux_if: DDRAM Avalon-style port bundle.
//   master: command/write-data driver (the mux) -- ADDR, BURSTCNT, RD, WE, DIN, BE out;
//           BUSY, DOUT_READY, DOUT in.
//   slave : the memory side, directions reversed.
interface ddram_mux_if;
  logic [28:0] DDRAM_ADDR;
  logic [3:0]  DDRAM_BURSTCNT;
  logic        DDRAM_RD;
  logic        DDRAM_WE;
  logic [63:0] DDRAM_DIN;
  logic [7:0]  DDRAM_BE;
  logic        DDRAM_BUSY;
  logic        DDRAM_DOUT_READY;
  logic [63:0] DDRAM_DOUT;

  modport master (
    output DDRAM_ADDR, DDRAM_BURSTCNT, DDRAM_RD, DDRAM_WE, DDRAM_DIN, DDRAM_BE,
    input  DDRAM_BUSY, DDRAM_DOUT_READY, DDRAM_DOUT
  );

  modport slave (
    input  DDRAM_ADDR, DDRAM_BURSTCNT, DDRAM_RD, DDRAM_WE, DDRAM_DIN, DDRAM_BE,
    output DDRAM_BUSY, DDRAM_DOUT_READY, DDRAM_DOUT
  );
endinterface

// File: rtl/ddram_mux.sv
// ddram_mux: arbitrates the DDRAM port between ioctl download writes and
// NUM_CH burst read channels (round-robin, writes first).
//   clk_sys, reset_n        : sole clock, synchronous active-low reset
//   ioctl_download/wr/addr/dout, ioctl_wait : 16-bit download write path
//   ch_req/addr/len -> ch_ack : per-channel read command handshake
//   ch_valid/ch_last/ch_data  : returned beats, data shared by all channels
//   ddr                       : DDRAM command/data bus (master side)
module ddram_mux #(
  parameter int          NUM_CH    = 2,
  parameter int          MAX_BURST = 4,
  parameter logic [28:0] DDR_BASE  = 29'h0600_0000
) (
  input  logic                   clk_sys,
  input  logic                   reset_n,
  input  logic                   ioctl_download,
  input  logic                   ioctl_wr,
  input  logic [26:0]            ioctl_addr,
  input  logic [15:0]            ioctl_dout,
  output logic                   ioctl_wait,
  input  logic [NUM_CH-1:0]      ch_req,
  input  logic [NUM_CH-1:0][28:0] ch_addr,
  input  logic [NUM_CH-1:0][3:0] ch_len,
  output logic [NUM_CH-1:0]      ch_ack,
  output logic [NUM_CH-1:0]      ch_valid,
  output logic                   ch_last,
  output logic [63:0]            ch_data,
  ddram_mux_if.master            ddr
);
  localparam int GW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {IDLE, WR, RD_CMD, RD_DATA} state_t;
  state_t state, nxt;

  logic          pending;
  logic [28:0]   wr_addr;
  logic [63:0]   wr_din;
  logic [7:0]    wr_be;
  logic [GW-1:0] last_grant, gnt, rr_sel, gnt_sel;
  logic          rr_hit, gnt_vld;
  logic [28:0]   cmd_addr;
  logic [63:0]   cmd_din;
  logic [7:0]    cmd_be;
  logic [3:0]    cmd_cnt, beat_cnt;
  logic          cap;
  logic [NUM_CH-1:0] gnt_oh;

  function automatic logic [3:0] clamp_len(input logic [3:0] l);
    if (l == 4'd0)                 return 4'd1;
    else if (l > 4'(MAX_BURST))    return 4'(MAX_BURST);
    else                           return l;
  endfunction

  // A strobe while a write is still pending is dropped, not queued.
  assign cap        = ioctl_wr & ioctl_download & ~pending;
  assign ioctl_wait = pending | (ioctl_wr & ioctl_download);
  assign gnt_oh     = NUM_CH'(1) << gnt;

  assign ddr.DDRAM_ADDR     = cmd_addr;
  assign ddr.DDRAM_BURSTCNT = cmd_cnt;
  assign ddr.DDRAM_DIN      = cmd_din;
  assign ddr.DDRAM_BE       = cmd_be;
  assign ddr.DDRAM_WE       = (state == WR);
  assign ddr.DDRAM_RD       = (state == RD_CMD);

  // First requester after last_grant, wrapping.
  always_comb begin
    int t;
    logic [GW-1:0] idx;
    rr_hit = 1'b0;
    rr_sel = last_grant;
    t      = 0;
    idx    = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      t = int'(last_grant) + i;
      if (t >= NUM_CH) t = t - NUM_CH;
      idx = GW'(t);
      if (!rr_hit && ch_req[idx]) begin
        rr_hit = 1'b1;
        rr_sel = idx;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) state <= IDLE;
    else          state <= nxt;
  end

  // The grant is registered one cycle before IDLE acts on it; the live
  // request is re-checked so a channel that dropped out is not served.
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (pending)                        nxt = WR;
               else if (gnt_vld && ch_req[gnt_sel]) nxt = RD_CMD;
      WR:      if (!ddr.DDRAM_BUSY)                 nxt = IDLE;
      RD_CMD:  if (!ddr.DDRAM_BUSY)                 nxt = RD_DATA;
      RD_DATA: if (ddr.DDRAM_DOUT_READY && beat_cnt == 4'd1) nxt = IDLE;
      default:                                      nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      pending    <= 1'b0;
      wr_addr    <= '0;
      wr_din     <= '0;
      wr_be      <= '0;
      last_grant <= GW'(NUM_CH - 1);
      gnt        <= '0;
      gnt_sel    <= '0;
      gnt_vld    <= 1'b0;
      cmd_addr   <= '0;
      cmd_din    <= '0;
      cmd_be     <= '0;
      cmd_cnt    <= 4'd1;
      beat_cnt   <= '0;
      ch_ack     <= '0;
      ch_valid   <= '0;
      ch_last    <= 1'b0;
      ch_data    <= '0;
    end else begin
      gnt_vld  <= rr_hit;
      gnt_sel  <= rr_sel;
      ch_ack   <= '0;
      ch_valid <= '0;
      ch_last  <= 1'b0;

      if (state == WR && !ddr.DDRAM_BUSY) begin
        pending <= 1'b0;
      end else if (cap) begin
        pending <= 1'b1;
        wr_addr <= DDR_BASE + 29'(ioctl_addr[26:3]);
        wr_din  <= {4{ioctl_dout}};
        wr_be   <= 8'b11 << {ioctl_addr[2:1], 1'b0};
      end

      if (state == IDLE && nxt == WR) begin
        cmd_addr <= wr_addr;
        cmd_din  <= wr_din;
        cmd_be   <= wr_be;
        cmd_cnt  <= 4'd1;
      end

      if (state == IDLE && nxt == RD_CMD) begin
        gnt      <= gnt_sel;
        cmd_addr <= DDR_BASE + ch_addr[gnt_sel];
        cmd_cnt  <= clamp_len(ch_len[gnt_sel]);
      end

      if (state == RD_CMD && !ddr.DDRAM_BUSY) begin
        ch_ack     <= gnt_oh;
        beat_cnt   <= cmd_cnt;
        last_grant <= gnt;
      end

      // Beats seen outside RD_DATA (e.g. left over across a reset) are dropped.
      if (state == RD_DATA && ddr.DDRAM_DOUT_READY) begin
        ch_data  <= ddr.DDRAM_DOUT;
        ch_valid <= gnt_oh;
        ch_last  <= (beat_cnt == 4'd1);
        beat_cnt <= beat_cnt - 4'd1;
      end
    end
  end
endmodule

// File: doc/ddram_mux.md
# ddram_mux

Multi-client arbiter between the ROM download path and the core's DDRAM read clients. It replaces the fixed single-beat DDRAM wiring in the top level. It has two jobs: commit `hps_io` ioctl words into DDRAM with byte enables and `ioctl_wait` back-pressure, and serve NUM_CH read channels with variable-length bursts under round-robin arbitration. It sits between `hps_io`/PGM core and the DDRAM Avalon port, all on `clk_sys` (CLK_50M).

## Interface
Parameters:
- NUM_CH, 2 — number of read channels, 1..8.
- MAX_BURST, 4 — largest burst issued, 1..15.
- DDR_BASE, 29'h0600_0000 — 64-bit-word base added to all addresses.

Ports:
- clk_sys  in  1  system clock; sole clock.
- reset_n  in  1  synchronous, active-low reset.
- ioctl_download  in  1  download active; ioctl_wr ignored when 0.
- ioctl_wr  in  1  one-cycle write strobe.
- ioctl_addr  in  27  byte address, 16-bit aligned.
- ioctl_dout  in  16  write data.
- ioctl_wait  out  1  high while a write is pending.
- ch_req  in  NUM_CH  per-channel read request; held until ch_ack.
- ch_addr  in  NUM_CH*29  per-channel 64-bit-word offset.
- ch_len  in  NUM_CH*4  per-channel beat count.
- ch_ack  out  NUM_CH  one-cycle pulse when the channel's command is accepted.
- ch_valid  out  NUM_CH  one-cycle pulse per returned beat.
- ch_last  out  1  qualifies the final beat.
- ch_data  out  64  beat data, shared by all channels.
- DDRAM_ADDR  out  29; DDRAM_BURSTCNT  out  4; DDRAM_RD, DDRAM_WE  out  1; DDRAM_DIN  out  64; DDRAM_BE  out  8.
- DDRAM_BUSY, DDRAM_DOUT_READY  in  1; DDRAM_DOUT  in  64.

## Operation
- **Write capture.** When `ioctl_wr & ioctl_download`, latch a pending write:
  - addr = DDR_BASE + ioctl_addr[26:3].
  - lane k = ioctl_addr[2:1].
  - DIN = ioctl_dout replicated to all four lanes.
  - BE = 2'b11 << 2k. For example, addr 6 gives BE 8'hC0.
- **ioctl_wait.** `ioctl_wait = pending | (ioctl_wr & ioctl_download)`, combinational. A strobe that arrives while a write is already pending is a protocol violation and is dropped.
- **FSM states:** IDLE, WR, RD_CMD, RD_DATA.
- **IDLE.**
  - If a write is pending, go to WR. Writes have priority over reads.
  - Otherwise, if any ch_req is high, grant the first requester after last_grant (round-robin, wrapping at NUM_CH-1). Latch its address and length, then go to RD_CMD.
  - DDRAM_DOUT_READY is ignored in IDLE.
- **Length rule.** len = ch_len; 0 maps to 1; any value above MAX_BURST maps to MAX_BURST.
- **WR.**
  - Drive DDRAM_WE=1 with the latched ADDR/DIN/BE and BURSTCNT=1.
  - The command is accepted on the first cycle with DDRAM_BUSY=0.
  - On acceptance: clear pending, go to IDLE.
- **RD_CMD.**
  - Drive DDRAM_RD=1, ADDR = DDR_BASE + ch_addr, BURSTCNT = len.
  - On acceptance (!DDRAM_BUSY): pulse ch_ack[g], load the beat counter with len, update last_grant, go to RD_DATA.
- **RD_DATA.**
  - Each DDRAM_DOUT_READY registers DDRAM_DOUT into ch_data, pulses ch_valid[g] and decrements the counter.
  - ch_last accompanies the beat on which the counter reaches 0; the FSM then returns to IDLE.
  - A write captured during RD_DATA waits; bursts are never interrupted.
- **Idle bus values.** Command outputs are held stable while BUSY is high. DDRAM_RD and DDRAM_WE are 0 outside their own states.

## Timing
- **Reset values (reset_n=0 at a clk_sys edge):** FSM=IDLE, pending=0, last_grant=NUM_CH-1 (so channel 0 wins first), ioctl_wait=0, DDRAM_RD=DDRAM_WE=0, DDRAM_ADDR=0, DDRAM_DIN=0, DDRAM_BE=0, DDRAM_BURSTCNT=1, ch_ack=0, ch_valid=0, ch_last=0, ch_data=0.
- **Reset mid-operation:** the reset values above apply, the in-flight write is lost, and leftover read beats arrive in IDLE and are discarded.
- **Write latency:** ioctl_wr at cycle T; DDRAM_WE high from T+2 (T+1 capture, T+2 IDLE→WR output registered); ioctl_wait falls the cycle after acceptance.
- **Read latency:** ch_req seen at T; DDRAM_RD high from T+2; ch_ack in the cycle following the accept edge; ch_valid one cycle after each DOUT_READY.
- **Back-to-back:** minimum one IDLE cycle between commands.

## Test plan
- **Reset:** reset_n=0 for 3 cycles with DOUT_READY toggling → every output at its reset value, no ch_valid.
- **Write lane:** ioctl_download=1, ioctl_wr with addr 27'h000006, data 16'hBEEF, BUSY high 3 cycles → DDRAM_WE held 4 cycles with ADDR=29'h0600_0000, BE=8'hC0, DIN[63:48]=16'hBEEF; ioctl_wait high throughout and low after accept.
- **Burst read:** ch_req[1] with addr 29'h10 and len 4, 4 DOUT_READY beats with data 1..4 → one ch_ack[1], DDRAM_ADDR=29'h0600_0010, BURSTCNT=4, ch_valid[1] ×4 carrying 1..4, ch_last on beat 4 only.
- **Length clamp:** len 0 → BURSTCNT 1 with ch_last on the first beat; len 9 with MAX_BURST=4 → BURSTCNT 4 and 4 beats.
- **Arbitration:** both channels request continuously while a write arrives during channel 0's burst → order ch0 burst, write, ch1, ch0, with grants strictly alternating between channels.
- **Reset mid-burst:** reset asserted after beat 2 of 4, then beats 3–4 arrive → no ch_valid; the next ch_req is served normally.
